// File: rtl/interpolation_pkg.sv
// Shared types for the interpolation engine: Q32.32 word, RAM map offsets, FSM encodings.
package interpolation_pkg;

    localparam int unsigned Q_W = 64;

    typedef logic signed [Q_W-1:0] q32_32_t;

    localparam q32_32_t ONE = 64'sh0000_0001_0000_0000;

    // Fixed table layout: [0]=N, [1]=T, [2..N+1]=t_i, [N+2..2N+1]=u_i, [2N+2]=result
    localparam int unsigned N_ADDR = 0;
    localparam int unsigned T_ADDR = 1;
    localparam int unsigned T_BASE = 2;

    typedef enum logic [3:0] {
        INIT_IDLE   = 4'd0,
        INIT_READ_N = 4'd1,
        INIT_SCAN   = 4'd2,
        INIT_DONE   = 4'd3,
        INIT_ERR    = 4'd4
    } init_state_t;

    typedef enum logic [3:0] {
        INTERP_IDLE   = 4'd0,
        INTERP_SEARCH = 4'd1,
        INTERP_SUB    = 4'd2,
        INTERP_DIV    = 4'd3,
        INTERP_MUL    = 4'd4,
        INTERP_WRITE  = 4'd5,
        INTERP_DONE   = 4'd6,
        INTERP_ERR    = 4'd7
    } interp_state_t;

endpackage

// File: rtl/interpolation_divider.sv
// Unsigned restoring divider producing QW quotient bits of (numer << QW) / denom.
// Caller guarantees numer < denom, so the quotient fits in QW bits.
module interpolation_divider #(
    parameter int unsigned DW = 64,
    parameter int unsigned QW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] numer,
    input  logic [DW-1:0] denom,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int unsigned CW = $clog2(QW);

    logic [DW-1:0] rem;
    logic [DW-1:0] den;
    logic [CW-1:0] cnt;
    logic [DW:0]   shifted_c;
    logic          ge_c;
    logic [DW-1:0] rem_next_c;

    // One quotient bit per cycle: shift remainder, subtract divisor when it fits
    always_comb begin
        shifted_c  = {rem, 1'b0};
        ge_c       = shifted_c >= {1'b0, den};
        rem_next_c = shifted_c[DW-1:0];
        if (ge_c) begin
            rem_next_c = DW'(shifted_c - {1'b0, den});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            den      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem      <= rem_next_c;
                quotient <= {quotient[QW-2:0], ge_c};
                cnt      <= cnt + CW'(1);
                if (cnt == CW'(QW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                rem      <= numer;
                den      <= denom;
                quotient <= '0;
                cnt      <= '0;
                busy     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/interpolation_core.sv
// Piecewise-linear interpolation engine: validates a sample table in RAM, then computes u(T).
// Build option INTERP_CLAMP_EN: out-of-range T writes the nearest end sample instead of erroring.
module interpolation_core
    import interpolation_pkg::*;
#(
    parameter int unsigned RAM_ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned RAM_DEPTH         = 50
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Interpolation_Enable,
    input  logic                         Interpolation_Intialize,
    output logic                         Memory_WR_Enable,
    input  logic [DATA_WIDTH-1:0]        RAM_RD1_Data,
    input  logic [DATA_WIDTH-1:0]        RAM_RD2_Data,
    output logic [DATA_WIDTH-1:0]        RAM_WR_Data,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD1_Address,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD2_Address,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address,
    output logic                         Interpolation_Done,
    output logic                         Intialization_Done,
    output logic                         Error,
    output logic [3:0]                   intialization_state,
    output logic [3:0]                   interpolation_state
);

    localparam int unsigned AW    = RAM_ADDRESS_WIDTH;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned FW    = DATA_WIDTH / 2;
    localparam int unsigned MAX_N = (RAM_DEPTH - 3) / 2;

    init_state_t   init_state,   init_next;
    interp_state_t interp_state, interp_next;

    logic                 initialized;
    logic                 t_valid;
    logic [AW-1:0]        n_reg;
    logic [AW-1:0]        scan_idx;
    logic [AW-1:0]        k_idx;
    logic signed [DW-1:0] t_reg;
    logic signed [DW-1:0] prev_t, prev_u;
    logic signed [DW-1:0] t_lo, t_hi, u_lo, u_hi;
    logic signed [DW-1:0] du;

    logic signed [DW-1:0]   rd1_s, rd2_s;
    logic                   both_idle_c, init_start_c, interp_start_c;
    logic                   n_bad_c, scan_last_c;
    logic                   hit_c, below_c, oor_c;
    logic                   take_u_c, bracket_c;
    logic                   div_start_c, div_busy, div_done;
    logic [DW-1:0]          div_numer_c, div_denom_c;
    logic [FW-1:0]          frac;
    logic signed [2*DW-1:0] prod_c;
    logic signed [DW-1:0]   result_c;

    assign rd1_s = $signed(RAM_RD1_Data);
    assign rd2_s = $signed(RAM_RD2_Data);

    // Starts only from a fully idle engine; initialize has priority over enable
    assign both_idle_c    = (init_state == INIT_IDLE) && (interp_state == INTERP_IDLE);
    assign init_start_c   = both_idle_c && Interpolation_Intialize;
    assign interp_start_c = both_idle_c && Interpolation_Enable && !Interpolation_Intialize;

    assign n_bad_c     = (rd1_s < $signed(DW'(2))) || (rd1_s > $signed(DW'(MAX_N)));
    assign scan_last_c = scan_idx == (n_reg - AW'(2));

    // Search compares T against t_k on RD1 while RD2 carries u_k
    assign hit_c   = rd1_s == t_reg;
    assign below_c = t_reg < rd1_s;
    assign oor_c   = (below_c && (k_idx == '0))
                   || (!below_c && !hit_c && (k_idx == (n_reg - AW'(1))));

    assign div_start_c = (interp_state == INTERP_SUB) && !div_busy;
    assign div_numer_c = DW'(t_reg - t_lo);
    assign div_denom_c = DW'(t_hi - t_lo);

    // Signed slope times unsigned fraction, truncated back to Q32.32
    assign prod_c   = $signed({{DW{du[DW-1]}}, du}) * $signed({{(2*DW-FW){1'b0}}, frac});
    assign result_c = u_lo + DW'(prod_c >>> FW);

    interpolation_divider #(
        .DW (DW),
        .QW (FW)
    ) u_divider (
        .clk      (CLK),
        .rst      (RST),
        .start    (div_start_c),
        .numer    (div_numer_c),
        .denom    (div_denom_c),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (frac)
    );

    always_comb begin
        init_next   = init_state;
        interp_next = interp_state;
        take_u_c    = 1'b0;
        bracket_c   = 1'b0;

        unique case (init_state)
            INIT_IDLE:   if (init_start_c) init_next = INIT_READ_N;
            INIT_READ_N: init_next = n_bad_c ? INIT_ERR : INIT_SCAN;
            INIT_SCAN: begin
                if (!(rd2_s > rd1_s)) begin
                    init_next = INIT_ERR;
                end else if (scan_last_c) begin
                    init_next = INIT_DONE;
                end
            end
            INIT_DONE:   init_next = INIT_IDLE;
            INIT_ERR:    init_next = INIT_IDLE;
            default:     init_next = INIT_IDLE;
        endcase

        unique case (interp_state)
            INTERP_IDLE: begin
                if (interp_start_c) begin
                    interp_next = initialized ? INTERP_SEARCH : INTERP_ERR;
                end
            end
            INTERP_SEARCH: begin
                if (t_valid) begin
                    if (hit_c) begin
                        take_u_c    = 1'b1;
                        interp_next = INTERP_WRITE;
                    end else if (oor_c) begin
`ifdef INTERP_CLAMP_EN
                        take_u_c    = 1'b1;
                        interp_next = INTERP_WRITE;
`else
                        interp_next = INTERP_ERR;
`endif
                    end else if (below_c) begin
                        bracket_c   = 1'b1;
                        interp_next = INTERP_SUB;
                    end
                end
            end
            INTERP_SUB:   interp_next = INTERP_DIV;
            INTERP_DIV:   if (div_done) interp_next = INTERP_MUL;
            INTERP_MUL:   interp_next = INTERP_WRITE;
            INTERP_WRITE: interp_next = INTERP_DONE;
            INTERP_DONE:  interp_next = INTERP_IDLE;
            INTERP_ERR:   interp_next = INTERP_IDLE;
            default:      interp_next = INTERP_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_state         <= INIT_IDLE;
            interp_state       <= INTERP_IDLE;
            initialized        <= 1'b0;
            t_valid            <= 1'b0;
            n_reg              <= '0;
            scan_idx           <= '0;
            k_idx              <= '0;
            t_reg              <= '0;
            prev_t             <= '0;
            prev_u             <= '0;
            t_lo               <= '0;
            t_hi               <= '0;
            u_lo               <= '0;
            u_hi               <= '0;
            du                 <= '0;
            Memory_WR_Enable   <= 1'b0;
            RAM_WR_Data        <= '0;
            RAM_RD1_Address    <= '0;
            RAM_RD2_Address    <= '0;
            RAM_WR_Address     <= '0;
            Interpolation_Done <= 1'b0;
            Intialization_Done <= 1'b0;
            Error              <= 1'b0;
        end else begin
            init_state         <= init_next;
            interp_state       <= interp_next;
            Memory_WR_Enable   <= interp_next == INTERP_WRITE;
            Interpolation_Done <= interp_next == INTERP_DONE;
            Intialization_Done <= init_next == INIT_DONE;

            if (init_start_c) begin
                Error       <= 1'b0;
                initialized <= 1'b0;
            end else begin
                if ((init_next == INIT_ERR) || (interp_next == INTERP_ERR)) Error <= 1'b1;
                if (init_next == INIT_DONE) initialized <= 1'b1;
            end

            // Table validation datapath
            case (init_state)
                INIT_IDLE: if (init_start_c) RAM_RD1_Address <= AW'(N_ADDR);
                INIT_READ_N: begin
                    n_reg           <= AW'(RAM_RD1_Data);
                    scan_idx        <= '0;
                    RAM_RD1_Address <= AW'(T_BASE);
                    RAM_RD2_Address <= AW'(T_BASE + 1);
                end
                INIT_SCAN: begin
                    scan_idx        <= scan_idx + AW'(1);
                    RAM_RD1_Address <= RAM_RD1_Address + AW'(1);
                    RAM_RD2_Address <= RAM_RD2_Address + AW'(1);
                end
                default: ;
            endcase

            // Interpolation datapath; first search cycle fetches T itself
            case (interp_state)
                INTERP_IDLE: begin
                    if (interp_start_c) begin
                        RAM_RD1_Address <= AW'(T_ADDR);
                        t_valid         <= 1'b0;
                        k_idx           <= '0;
                    end
                end
                INTERP_SEARCH: begin
                    if (!t_valid) begin
                        t_reg           <= rd1_s;
                        t_valid         <= 1'b1;
                        RAM_RD1_Address <= AW'(T_BASE);
                        RAM_RD2_Address <= AW'(T_BASE) + n_reg;
                    end else begin
                        prev_t          <= rd1_s;
                        prev_u          <= rd2_s;
                        k_idx           <= k_idx + AW'(1);
                        RAM_RD1_Address <= RAM_RD1_Address + AW'(1);
                        RAM_RD2_Address <= RAM_RD2_Address + AW'(1);
                    end
                    if (bracket_c) begin
                        t_lo <= prev_t;
                        u_lo <= prev_u;
                        t_hi <= rd1_s;
                        u_hi <= rd2_s;
                    end
                    if (take_u_c) RAM_WR_Data <= RAM_RD2_Data;
                end
                INTERP_SUB: du <= u_hi - u_lo;
                INTERP_MUL: RAM_WR_Data <= result_c;
                default: ;
            endcase

            if (interp_next == INTERP_WRITE) RAM_WR_Address <= AW'(T_BASE) + (n_reg << 1);
        end
    end

    assign intialization_state = init_state;
    assign interpolation_state = interp_state;

endmodule

// File: tb/tb_interpolation_core.sv
// Directed bench for interpolation_core with a behavioural dual-read/single-write RAM.
module tb_interpolation_core;
    import interpolation_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 64;
    localparam logic [DW-1:0] SENT = 64'hDEAD_BEEF_0000_0001;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Interpolation_Enable = 1'b0;
    logic          Interpolation_Intialize = 1'b0;
    logic          Memory_WR_Enable;
    logic [DW-1:0] RAM_RD1_Data, RAM_RD2_Data, RAM_WR_Data;
    logic [AW-1:0] RAM_RD1_Address, RAM_RD2_Address, RAM_WR_Address;
    logic          Interpolation_Done, Intialization_Done, Error;
    logic [3:0]    intialization_state, interpolation_state;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_data = '0;
    int wr_cnt = 0, idone_cnt = 0, ndone_cnt = 0;
    int total = 0, bad = 0;
    int cyc, w0, i0, n0;

    interpolation_core dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .Interpolation_Enable    (Interpolation_Enable),
        .Interpolation_Intialize (Interpolation_Intialize),
        .Memory_WR_Enable        (Memory_WR_Enable),
        .RAM_RD1_Data            (RAM_RD1_Data),
        .RAM_RD2_Data            (RAM_RD2_Data),
        .RAM_WR_Data             (RAM_WR_Data),
        .RAM_RD1_Address         (RAM_RD1_Address),
        .RAM_RD2_Address         (RAM_RD2_Address),
        .RAM_WR_Address          (RAM_WR_Address),
        .Interpolation_Done      (Interpolation_Done),
        .Intialization_Done      (Intialization_Done),
        .Error                   (Error),
        .intialization_state     (intialization_state),
        .interpolation_state     (interpolation_state)
    );

    always #5 CLK = ~CLK;

    assign RAM_RD1_Data = mem[RAM_RD1_Address];
    assign RAM_RD2_Data = mem[RAM_RD2_Address];

    always @(posedge CLK) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (Memory_WR_Enable) mem[RAM_WR_Address] <= RAM_WR_Data;
        if (Memory_WR_Enable) wr_cnt <= wr_cnt + 1;
        if (Interpolation_Done) idone_cnt <= idone_cnt + 1;
        if (Intialization_Done) ndone_cnt <= ndone_cnt + 1;
    end

    function automatic logic [DW-1:0] q(input longint x);
        q32_32_t r;
        r = q32_32_t'(x) * ONE;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        tb_we = 1'b1;
        tb_addr = AW'(a);
        tb_data = d;
        @(negedge CLK);
        tb_we = 1'b0;
    endtask

    task automatic load_t(input longint t0, input longint t1, input longint t2);
        poke(2, q(t0)); poke(3, q(t1)); poke(4, q(t2));
    endtask

    task automatic load_u(input longint u0, input longint u1, input longint u2);
        poke(5, q(u0)); poke(6, q(u1)); poke(7, q(u2));
    endtask

    // Pulse the start inputs for one cycle and wait (bounded) for both FSMs to idle
    task automatic run(input logic init, input logic en, output int cycles);
        w0 = wr_cnt; i0 = idone_cnt; n0 = ndone_cnt;
        Interpolation_Intialize = init;
        Interpolation_Enable = en;
        @(negedge CLK);
        Interpolation_Intialize = 1'b0;
        Interpolation_Enable = 1'b0;
        cycles = 1;
        while ((intialization_state != 4'd0 || interpolation_state != 4'd0) && cycles < 300) begin
            @(negedge CLK);
            cycles++;
        end
        @(negedge CLK);
        chk("op_timeout", 64'(cycles < 300), 64'd1);
    endtask

    task automatic interp_at(input string tag, input longint t, input logic [DW-1:0] exp);
        poke(1, q(t));
        poke(8, SENT);
        run(1'b0, 1'b1, cyc);
        chk(tag, mem[8], exp);
        chk({tag, "_wr"}, 64'(wr_cnt - w0), 64'd1);
        chk({tag, "_done"}, 64'(idone_cnt - i0), 64'd1);
    endtask

    initial begin
        #2 RST = 1'b1;
        @(negedge CLK);
        chk("rst_wr_en", 64'(Memory_WR_Enable), 64'd0);
        chk("rst_idone", 64'(Interpolation_Done), 64'd0);
        chk("rst_ndone", 64'(Intialization_Done), 64'd0);
        chk("rst_error", 64'(Error), 64'd0);
        chk("rst_states", 64'({intialization_state, interpolation_state}), 64'd0);
        chk("rst_addr", 64'({RAM_RD1_Address, RAM_RD2_Address, RAM_WR_Address}), 64'd0);
        chk("rst_wdata", RAM_WR_Data, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Table A: N=3, t={0,2,4}, u={10,20,40}
        poke(0, 64'd3);
        load_t(0, 2, 4);
        load_u(10, 20, 40);
        poke(8, SENT);
        run(1'b1, 1'b0, cyc);
        chk("init_err", 64'(Error), 64'd0);
        chk("init_done", 64'(ndone_cnt - n0), 64'd1);

        interp_at("t3", 3, q(30));
        chk("t3_err", 64'(Error), 64'd0);
        interp_at("t2_hit", 2, q(20));
        chk("t2_fast", 64'(cyc < 20), 64'd1);
        interp_at("t1_5", 0, q(10));
        poke(1, 64'h0000_0001_8000_0000);
        poke(8, SENT);
        run(1'b0, 1'b1, cyc);
        chk("t1.5", mem[8], 64'h0000_0011_8000_0000);
        interp_at("t4_last", 4, q(40));

        // Simultaneous start: initialize wins
        run(1'b1, 1'b1, cyc);
        chk("both_init", 64'(ndone_cnt - n0), 64'd1);
        chk("both_noint", 64'(idone_cnt - i0), 64'd0);
        chk("both_nowr", 64'(wr_cnt - w0), 64'd0);

        // Out of range high and low
        poke(1, q(5));
        poke(8, SENT);
        run(1'b0, 1'b1, cyc);
`ifdef INTERP_CLAMP_EN
        chk("t5_clamp", mem[8], q(40));
        chk("t5_err", 64'(Error), 64'd0);
`else
        chk("t5_mem", mem[8], SENT);
        chk("t5_err", 64'(Error), 64'd1);
        chk("t5_nowr", 64'(wr_cnt - w0), 64'd0);
        chk("t5_nodone", 64'(idone_cnt - i0), 64'd0);
`endif
        run(1'b1, 1'b0, cyc);
        chk("reinit_clr", 64'(Error), 64'd0);
        poke(1, q(-1));
        poke(8, SENT);
        run(1'b0, 1'b1, cyc);
`ifdef INTERP_CLAMP_EN
        chk("tm1_clamp", mem[8], q(10));
`else
        chk("tm1_mem", mem[8], SENT);
        chk("tm1_err", 64'(Error), 64'd1);
`endif
        run(1'b1, 1'b0, cyc);

        // Negative slope
        load_u(10, 0, -40);
        interp_at("neg_t1", 1, q(5));
        interp_at("neg_t3", 3, q(-20));
        chk("neg_err", 64'(Error), 64'd0);

        // Non-increasing t, then enable without a valid table
        load_t(0, 2, 2);
        run(1'b1, 1'b0, cyc);
        chk("dup_err", 64'(Error), 64'd1);
        chk("dup_nodone", 64'(ndone_cnt - n0), 64'd0);
        poke(8, SENT);
        run(1'b0, 1'b1, cyc);
        chk("dup_en_err", 64'(Error), 64'd1);
        chk("dup_en_nowr", 64'(wr_cnt - w0), 64'd0);
        chk("dup_en_mem", mem[8], SENT);

        // N bounds
        load_t(0, 2, 4);
        poke(0, 64'd1);
        run(1'b1, 1'b0, cyc);
        chk("n1_err", 64'(Error), 64'd1);
        chk("n1_nodone", 64'(ndone_cnt - n0), 64'd0);
        poke(0, 64'd24);
        run(1'b1, 1'b0, cyc);
        chk("n24_err", 64'(Error), 64'd1);

        // Reset while dividing
        poke(0, 64'd3);
        load_u(10, 20, 40);
        run(1'b1, 1'b0, cyc);
        chk("pre_rst_err", 64'(Error), 64'd0);
        poke(1, q(3));
        poke(8, SENT);
        w0 = wr_cnt;
        Interpolation_Enable = 1'b1;
        @(negedge CLK);
        Interpolation_Enable = 1'b0;
        cyc = 0;
        while (interpolation_state != 4'd3 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
        end
        chk("reach_div", 64'(interpolation_state), 64'd3);
        RST = 1'b1;
        #1;
        chk("mid_rst_state", 64'(interpolation_state), 64'd0);
        chk("mid_rst_wr_en", 64'(Memory_WR_Enable), 64'd0);
        chk("mid_rst_addr", 64'({RAM_RD1_Address, RAM_RD2_Address, RAM_WR_Address}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_nowr", 64'(wr_cnt - w0), 64'd0);
        chk("mid_rst_mem", mem[8], SENT);
        run(1'b0, 1'b1, cyc);
        chk("uninit_err", 64'(Error), 64'd1);
        chk("uninit_nowr", 64'(wr_cnt - w0), 64'd0);
        run(1'b1, 1'b0, cyc);
        chk("rerun_init", 64'(ndone_cnt - n0), 64'd1);
        interp_at("rerun_t3", 3, q(30));
        chk("rerun_err", 64'(Error), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
